// File: rtl/float_mul_seq.sv
// float_mul_seq: iterative IEEE-754 single-precision multiplier.
// Operands are latched on an accepted start, classified, multiplied with a
// 24-step shift-add loop, normalised with truncation and returned with a
// one-cycle done pulse. Denormal inputs are flushed to zero.
module float_mul_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [EXP_W+MANT_W:0]     dataa,
  input  logic [EXP_W+MANT_W:0]     datab,
  output logic                      busy,
  output logic                      done,
  output logic [EXP_W+MANT_W:0]     result
);

  localparam int W  = 1 + EXP_W + MANT_W;
  localparam int MW = MANT_W + 1;
  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW);
  localparam int XW = EXP_W + 2;

  localparam logic [CW-1:0]        CNT_LAST = CW'(MW - 1);
  localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MULT,
    NORM,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  a_q, b_q;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          spec_q;
  logic [W-1:0]  spec_res_q;

  // Operand field decode and special-case classification
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic [MW-1:0]     ma, mb;
  logic              sign;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              is_special;
  logic [W-1:0]      special_val;
  logic [W-1:0]      qnan, inf_res, zero_res;

  // Normalisation of the finished accumulator
  logic signed [XW-1:0] exp_n;
  logic [MANT_W-1:0]    mant_n;
  logic [W-1:0]         norm_res;

  assign ea   = a_q[W-2:MANT_W];
  assign eb   = b_q[W-2:MANT_W];
  assign fa   = a_q[MANT_W-1:0];
  assign fb   = b_q[MANT_W-1:0];
  assign ma   = {1'b1, fa};
  assign mb   = {1'b1, fb};
  assign sign = a_q[W-1] ^ b_q[W-1];

  assign qnan     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
  assign inf_res  = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
  assign zero_res = {sign, {(W-1){1'b0}}};

  // Classify latched operands; priority NaN, Inf*0, Inf, zero
  always_comb begin
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    is_special  = 1'b1;
    special_val = '0;
    if (a_nan || b_nan) begin
      special_val = qnan;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      special_val = qnan;
    end else if (a_inf || b_inf) begin
      special_val = inf_res;
    end else if (a_zero || b_zero) begin
      special_val = zero_res;
    end else begin
      is_special = 1'b0;
    end
  end

  // Normalise the product, truncate, and saturate the exponent
  always_comb begin
    exp_n = signed'({2'b00, ea}) + signed'({2'b00, eb}) - BIAS_X
          + signed'({{(XW-1){1'b0}}, acc[PW-1]});
    mant_n = acc[PW-1] ? acc[PW-2 -: MANT_W] : acc[PW-3 -: MANT_W];
    if (exp_n >= EXP_MAX) begin
      norm_res = inf_res;
    end else if (exp_n <= 0) begin
      norm_res = zero_res;
    end else begin
      norm_res = {sign, exp_n[EXP_W-1:0], mant_n};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CHECK;
      // Special results still pass through NORM so their latency is two
      // cycles after start; NORM then selects the pre-computed value.
      CHECK: state_nxt = is_special ? NORM : MULT;
      MULT:  if (cnt == CNT_LAST) state_nxt = NORM;
      NORM:  state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Operand latch, shift-add loop and result register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      cnt        <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= dataa;
            b_q <= datab;
          end
        end
        CHECK: begin
          acc        <= '0;
          cnt        <= '0;
          spec_q     <= is_special;
          spec_res_q <= special_val;
        end
        MULT: begin
          if (mb[cnt]) begin
            acc <= acc + ({{MW{1'b0}}, ma} << cnt);
          end
          cnt <= cnt + 1'b1;
        end
        NORM: begin
          result <= spec_q ? spec_res_q : norm_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_mul_seq.sv
// Directed bench for float_mul_seq: reset state, products, specials,
// exponent limits, ignored starts and mid-operation reset.
module tb_float_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] dataa, datab;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  float_mul_seq #(.EXP_W(8), .MANT_W(23), .BIAS(127)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .dataa   (dataa),
    .datab   (datab),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation: start sampled at edge k, count edges until done.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int exp_lat);
    int   n;
    logic seen;
    logic busy_ok;
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n       = 0;
    seen    = 1'b0;
    busy_ok = busy;
    while (!seen && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int   pulses;
    int   pulse_at;
    logic [31:0] res_at;

    reset_n = 1'b0;
    start   = 1'b0;
    dataa   = '0;
    datab   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'h0);
    reset_n = 1'b1;

    do_op("basic",   32'h40500000, 32'h40800000, 32'h41500000, 26);
    do_op("zero",    32'h41280000, 32'h00000000, 32'h00000000, 2);
    do_op("negzero", 32'h41280000, 32'h80000000, 32'h80000000, 2);
    do_op("neg2x3",  32'hC0000000, 32'h40400000, 32'hC0C00000, 26);
    do_op("carry",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 26);
    do_op("ovf",     32'h7F000000, 32'h7F000000, 32'h7F800000, 26);
    do_op("unf",     32'h00800000, 32'h00800000, 32'h00000000, 26);
    do_op("infzero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 2);
    do_op("inffin",  32'hFF800000, 32'h40000000, 32'hFF800000, 2);
    do_op("nan",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2);

    // Ignored starts at 5 and 26 cycles after the accepted one.
    @(negedge clk);
    dataa = 32'h40500000;
    datab = 32'h40800000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses   = 0;
    pulse_at = 0;
    res_at   = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        pulse_at = n;
        res_at   = result;
      end
      start = 1'b0;
      if (n == 4 || n == 25) begin
        dataa = 32'h3FC00000;
        datab = 32'h40400000;
        start = 1'b1;
      end
    end
    start = 1'b0;
    chk("hs_pulses", 32'(pulses), 32'd1);
    chk("hs_pulse_at", 32'(pulse_at), 32'd26);
    chk("hs_result", res_at, 32'h41500000);
    chk("hs_hold", result, 32'h41500000);
    chk("hs_idle", {31'b0, busy}, 32'd0);

    // Reset 10 cycles into an operation.
    @(negedge clk);
    dataa = 32'h3FC00000;
    datab = 32'h3FC00000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("mid_rst_no_done", 32'(pulses), 32'd0);
    do_op("after_rst", 32'h40500000, 32'h40800000, 32'h41500000, 26);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
